// File: rtl/ansi_pkg.sv
// ansi_pkg: shared definitions for the ANSI/VT100 receive-path decoder.
//   - cmd_e   : decoded command codes presented on o_cmd
//   - state_e : parser states
//   - CH_*    : control/introducer byte values
//   - default_one(): "0 or missing parameter means 1" rule for cursor commands
package ansi_pkg;

    typedef enum logic [3:0] {
        CMD_PUTC = 4'd0,
        CMD_CR   = 4'd1,
        CMD_LF   = 4'd2,
        CMD_BS   = 4'd3,
        CMD_TAB  = 4'd4,
        CMD_BEL  = 4'd5,
        CMD_CUU  = 4'd6,
        CMD_CUD  = 4'd7,
        CMD_CUF  = 4'd8,
        CMD_CUB  = 4'd9,
        CMD_CUP  = 4'd10,
        CMD_ED   = 4'd11,
        CMD_EL   = 4'd12,
        CMD_RIS  = 4'd13
    } cmd_e;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2
    } state_e;

    localparam logic [7:0] CH_ESC = 8'h1B;
    localparam logic [7:0] CH_CSI = 8'h5B; // '['
    localparam logic [7:0] CH_CAN = 8'h18;
    localparam logic [7:0] CH_SUB = 8'h1A;

    function automatic logic [7:0] default_one(input logic [7:0] v, input logic seen);
        return (!seen || v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/ansi_decoder_if.sv
// ansi_decoder_if: byte-in / command-out bundle of the ANSI decoder.
//   i_byte, i_byte_v            : received byte and its one-cycle strobe
//   o_cmd, o_char, o_arg0/1     : decoded command payload
//   o_cmd_v, o_err              : one-cycle command / error strobes
// slave modport is the decoder side, master modport the byte source / consumer.
interface ansi_decoder_if;
    logic [7:0] i_byte;
    logic       i_byte_v;
    logic [3:0] o_cmd;
    logic [7:0] o_char;
    logic [7:0] o_arg0;
    logic [7:0] o_arg1;
    logic       o_cmd_v;
    logic       o_err;

    modport slave (
        input  i_byte, i_byte_v,
        output o_cmd, o_char, o_arg0, o_arg1, o_cmd_v, o_err
    );

    modport master (
        output i_byte, i_byte_v,
        input  o_cmd, o_char, o_arg0, o_arg1, o_cmd_v, o_err
    );
endinterface

// File: rtl/ansi_param_acc.sv
// ansi_param_acc: saturating decimal accumulator for one CSI parameter.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the value and the seen flag
//   dv, digit  : append one decimal digit (0..9)
//   value      : accumulated value, clamped at PARAM_MAX
//   seen       : at least one digit received since clr
module ansi_param_acc #(
    parameter int unsigned PARAM_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       dv,
    input  logic [3:0] digit,
    output logic [7:0] value,
    output logic       seen
);

    logic [7:0]  value_q, value_d;
    logic        seen_q, seen_d;
    logic [11:0] next_wide;

    always_comb begin
        value_d = value_q;
        seen_d  = seen_q;
        // 255*10+9 fits in 12 bits, so the clamp sees the true product
        next_wide = 12'(value_q) * 12'd10 + 12'(digit);
        if (clr) begin
            value_d = '0;
            seen_d  = 1'b0;
        end else if (dv) begin
            seen_d  = 1'b1;
            value_d = (next_wide > 12'(PARAM_MAX)) ? 8'(PARAM_MAX) : next_wide[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            seen_q  <= seen_d;
        end
    end

    assign value = value_q;
    assign seen  = seen_q;

endmodule

// File: rtl/ansi_decoder.sv
// ansi_decoder: parses a VT100/ANSI subset from the uart_rx byte stream into
// one command per completed sequence for termbuffer.
//   clk, rst_n : 12 MHz clock, async active-low reset
//   bus        : ansi_decoder_if.slave (byte in, registered command/error out)
// A partial ESC/CSI sequence idle for TIMEOUT_CLKS clocks is dropped with o_err.
module ansi_decoder
    import ansi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 1200000,
    parameter int unsigned PARAM_MAX    = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    ansi_decoder_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [7:0]    char_q, char_d;
    logic [7:0]    arg0_q, arg0_d;
    logic [7:0]    arg1_q, arg1_d;
    logic          cmd_v_q, cmd_v_d;
    logic          err_q, err_d;

    logic       acc_clr, acc_dv0, acc_dv1;
    logic [7:0] p0, p1;
    logic       seen0, seen1;

    // payload staged by the parser, committed only when emit is set
    logic       emit;
    cmd_e       emit_cmd;
    logic [7:0] emit_char, emit_a0, emit_a1;

    logic [7:0] b;
    logic       is_digit;

    assign b        = bus.i_byte;
    assign is_digit = (b >= 8'h30) && (b <= 8'h39);

    ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc0 (
        .clk(clk), .rst_n(rst_n), .clr(acc_clr), .dv(acc_dv0),
        .digit(b[3:0]), .value(p0), .seen(seen0)
    );

    ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc1 (
        .clk(clk), .rst_n(rst_n), .clr(acc_clr), .dv(acc_dv1),
        .digit(b[3:0]), .value(p1), .seen(seen1)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        char_d    = char_q;
        arg0_d    = arg0_q;
        arg1_d    = arg1_q;
        cmd_v_d   = 1'b0;
        err_d     = 1'b0;
        acc_clr   = 1'b0;
        acc_dv0   = 1'b0;
        acc_dv1   = 1'b0;
        emit      = 1'b0;
        emit_cmd  = CMD_PUTC;
        emit_char = '0;
        emit_a0   = '0;
        emit_a1   = '0;

        if (bus.i_byte_v) begin
            // a byte always wins over a coincident timer expiry
            timer_d = '0;
            unique case (state_q)
                ST_GROUND: begin
                    if (b >= 8'h20 && b <= 8'h7E) begin
                        emit      = 1'b1;
                        emit_cmd  = CMD_PUTC;
                        emit_char = b;
                    end else begin
                        case (b)
                            8'h0D:  begin emit = 1'b1; emit_cmd = CMD_CR;  end
                            8'h0A:  begin emit = 1'b1; emit_cmd = CMD_LF;  end
                            8'h08:  begin emit = 1'b1; emit_cmd = CMD_BS;  end
                            8'h09:  begin emit = 1'b1; emit_cmd = CMD_TAB; end
                            8'h07:  begin emit = 1'b1; emit_cmd = CMD_BEL; end
                            CH_ESC: state_d = ST_ESC;
                            default: ;
                        endcase
                    end
                end
                ST_ESC: begin
                    if (b == CH_CSI) begin
                        state_d = ST_CSI;
                        acc_clr = 1'b1;
                        idx_d   = '0;
                    end else if (b == 8'h63) begin // 'c'
                        emit     = 1'b1;
                        emit_cmd = CMD_RIS;
                        state_d  = ST_GROUND;
                    end else if (b != CH_ESC) begin
                        err_d   = 1'b1;
                        state_d = ST_GROUND;
                    end
                end
                ST_CSI: begin
                    if (is_digit) begin
                        // idx 2 means third-or-later parameter: parsed, discarded
                        acc_dv0 = (idx_q == 2'd0);
                        acc_dv1 = (idx_q == 2'd1);
                    end else if (b == 8'h3B) begin // ';'
                        if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
                    end else if (b == CH_ESC) begin
                        state_d = ST_ESC;
                    end else if (b == CH_CAN || b == CH_SUB) begin
                        state_d = ST_GROUND;
                    end else if (b >= 8'h40 && b <= 8'h7E) begin
                        state_d = ST_GROUND;
                        case (b)
                            8'h41: begin emit = 1'b1; emit_cmd = CMD_CUU; emit_a0 = default_one(p0, seen0); end
                            8'h42: begin emit = 1'b1; emit_cmd = CMD_CUD; emit_a0 = default_one(p0, seen0); end
                            8'h43: begin emit = 1'b1; emit_cmd = CMD_CUF; emit_a0 = default_one(p0, seen0); end
                            8'h44: begin emit = 1'b1; emit_cmd = CMD_CUB; emit_a0 = default_one(p0, seen0); end
                            8'h48, 8'h66: begin
                                emit     = 1'b1;
                                emit_cmd = CMD_CUP;
                                emit_a0  = default_one(p0, seen0);
                                emit_a1  = default_one(p1, seen1);
                            end
                            8'h4A, 8'h4B: begin
                                if (p0 > 8'd2) begin
                                    err_d = 1'b1;
                                end else begin
                                    emit     = 1'b1;
                                    emit_cmd = (b == 8'h4A) ? CMD_ED : CMD_EL;
                                    emit_a0  = seen0 ? p0 : 8'd0;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_GROUND;
                    end
                end
                default: state_d = ST_GROUND;
            endcase
        end else if (state_q == ST_GROUND) begin
            timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
            timer_d = '0;
            err_d   = 1'b1;
            state_d = ST_GROUND;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (emit) begin
            cmd_v_d = 1'b1;
            cmd_d   = emit_cmd;
            char_d  = emit_char;
            arg0_d  = emit_a0;
            arg1_d  = emit_a1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GROUND;
            timer_q <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            char_q  <= '0;
            arg0_q  <= '0;
            arg1_q  <= '0;
            cmd_v_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            char_q  <= char_d;
            arg0_q  <= arg0_d;
            arg1_q  <= arg1_d;
            cmd_v_q <= cmd_v_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_cmd   = cmd_q;
    assign bus.o_char  = char_q;
    assign bus.o_arg0  = arg0_q;
    assign bus.o_arg1  = arg1_q;
    assign bus.o_cmd_v = cmd_v_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_ansi_decoder.sv
// tb_ansi_decoder: directed-vector bench for ansi_decoder with a short
// inactivity timeout so the timer paths run in a few dozen clocks.
module tb_ansi_decoder;
    import ansi_pkg::*;

    localparam int unsigned TMO = 50;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ansi_decoder_if bus ();

    ansi_decoder #(.TIMEOUT_CLKS(TMO), .PARAM_MAX(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one byte strobe; returns 1 time unit after the sampling edge,
    // where the decoder's response to this byte is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte   = b;
        bus.i_byte_v = 1'b1;
        @(posedge clk);
        #1;
        bus.i_byte_v = 1'b0;
        bus.i_byte   = '0;
    endtask

    task automatic seq(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (i != s.len() - 1)
                check({tag, "_mid"}, {30'd0, bus.o_cmd_v, bus.o_err}, 32'd0);
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] cmd, input logic [7:0] ch,
                              input logic [7:0] a0, input logic [7:0] a1);
        check({tag, "_v"},    32'(bus.o_cmd_v), 32'd1);
        check({tag, "_err"},  32'(bus.o_err),   32'd0);
        check({tag, "_cmd"},  32'(bus.o_cmd),   32'(cmd));
        check({tag, "_char"}, 32'(bus.o_char),  32'(ch));
        check({tag, "_a0"},   32'(bus.o_arg0),  32'(a0));
        check({tag, "_a1"},   32'(bus.o_arg1),  32'(a1));
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_v"},   32'(bus.o_cmd_v), 32'd0);
        check({tag, "_err"}, 32'(bus.o_err),   32'd0);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_v"},   32'(bus.o_cmd_v), 32'd0);
        check({tag, "_err"}, 32'(bus.o_err),   32'd1);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, "_all"},
              {bus.o_cmd, bus.o_char, bus.o_arg0, bus.o_arg1, bus.o_cmd_v, bus.o_err},
              32'd0);
    endtask

    initial begin
        int early;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.i_byte   = '0;
        bus.i_byte_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // printable and C0 controls, each strobe one cycle after its byte
        send_byte(8'h41); expect_cmd("putc_A", CMD_PUTC, 8'h41, 8'd0, 8'd0);
        send_byte(8'h0D); expect_cmd("cr",     CMD_CR,   8'h00, 8'd0, 8'd0);
        send_byte(8'h0A); expect_cmd("lf",     CMD_LF,   8'h00, 8'd0, 8'd0);
        @(posedge clk); #1;
        expect_none("lf_drop");
        send_byte(8'h08); expect_cmd("bs",  CMD_BS,  8'h00, 8'd0, 8'd0);
        send_byte(8'h09); expect_cmd("tab", CMD_TAB, 8'h00, 8'd0, 8'd0);
        send_byte(8'h07); expect_cmd("bel", CMD_BEL, 8'h00, 8'd0, 8'd0);

        // cursor positioning
        seq("cup", "\033[12;40H");   expect_cmd("cup",     CMD_CUP, 8'h00, 8'd12, 8'd40);
        seq("cup_d", "\033[H");      expect_cmd("cup_d",   CMD_CUP, 8'h00, 8'd1,  8'd1);
        seq("cup_p1", "\033[;5H");   expect_cmd("cup_p1",  CMD_CUP, 8'h00, 8'd1,  8'd5);
        seq("cup_f", "\033[0;7f");   expect_cmd("cup_f",   CMD_CUP, 8'h00, 8'd1,  8'd7);
        seq("cup_3p", "\033[3;4;5H"); expect_cmd("cup_3p", CMD_CUP, 8'h00, 8'd3,  8'd4);

        // relative moves, saturation, erase
        seq("cuf", "\033[C");        expect_cmd("cuf",     CMD_CUF, 8'h00, 8'd1,   8'd0);
        seq("cud_sat", "\033[999B"); expect_cmd("cud_sat", CMD_CUD, 8'h00, 8'd255, 8'd0);
        seq("cub", "\033[6D");       expect_cmd("cub",     CMD_CUB, 8'h00, 8'd6,   8'd0);
        seq("ed", "\033[2J");        expect_cmd("ed",      CMD_ED,  8'h00, 8'd2,   8'd0);
        seq("el_d", "\033[K");       expect_cmd("el_d",    CMD_EL,  8'h00, 8'd0,   8'd0);
        seq("el_bad", "\033[5K");    expect_err("el_bad");
        seq("csi_q", "\033[?");      expect_err("csi_q");
        seq("csi_fin", "\033[1m");   expect_err("csi_fin");
        seq("esc_bad", "\033x");     expect_err("esc_bad");

        // timeout: o_err exactly TMO clocks after the '3' is sampled
        seq("tmo", "\033[3");
        expect_none("tmo_3");
        early = 0;
        for (int i = 1; i < int'(TMO); i++) begin
            @(posedge clk); #1;
            if (bus.o_err !== 1'b0 || bus.o_cmd_v !== 1'b0) early++;
        end
        check("tmo_early", early, 0);
        @(posedge clk); #1;
        expect_err("tmo_fire");
        send_byte(8'h78); expect_cmd("tmo_after", CMD_PUTC, 8'h78, 8'd0, 8'd0);

        // byte landing on the expiry cycle is processed, no timeout
        seq("tmo_co", "\033[3");
        repeat (TMO - 1) @(posedge clk);
        send_byte(8'h41); expect_cmd("tmo_co", CMD_CUU, 8'h00, 8'd3, 8'd0);
        @(posedge clk); #1;
        expect_none("tmo_co_post");

        // ESC restarts a sequence silently
        seq("restart", "\033[1\033[4A"); expect_cmd("restart", CMD_CUU, 8'h00, 8'd4, 8'd0);

        // reset mid-sequence
        seq("rst_mid", "\033[7");
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        expect_zero("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h42); expect_cmd("rst_B", CMD_PUTC, 8'h42, 8'd0, 8'd0);

        // CAN aborts silently
        seq("can", "\033[2\030");    expect_none("can");
        send_byte(8'h7A); expect_cmd("can_z", CMD_PUTC, 8'h7A, 8'd0, 8'd0);
        seq("sub", "\033[3\032");    expect_none("sub");

        // RIS and ignored high byte
        seq("ris", "\033c");         expect_cmd("ris", CMD_RIS, 8'h00, 8'd0, 8'd0);
        send_byte(8'h80);            expect_none("b80");
        send_byte(8'h7F);            expect_none("b7f");
        // payload held across ignored bytes
        check("hold_cmd", 32'(bus.o_cmd), 32'(CMD_RIS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ansi_decoder.md
Name: ansi_decoder

Overview:
Sits between uart_rx and termbuffer on the receive path. Consumes the raw byte strobe from uart_rx and parses a VT100/ANSI subset: printable characters, C0 controls, ESC c, and CSI sequences with up to two decimal parameters. Emits one decoded command per completed sequence, so termbuffer never sees escape syntax. An inactivity timer abandons half-received sequences.

Parameters:
TIMEOUT_CLKS, 1200000, clocks without a byte before a partial sequence is abandoned (100 ms at 12 MHz)
PARAM_MAX, 255, saturation value of each numeric parameter; must fit in 8 bits

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
i_byte  in  8  received byte from uart_rx
i_byte_v  in  1  one-cycle strobe; i_byte is valid this cycle
o_cmd  out  4  decoded command code (ansi_pkg CMD_*)
o_char  out  8  character for CMD_PUTC, else 0
o_arg0  out  8  first parameter (row, count or mode)
o_arg1  out  8  second parameter (column for CMD_CUP, else 0)
o_cmd_v  out  1  one-cycle strobe; o_cmd, o_char and the args are valid
o_err  out  1  one-cycle strobe on a malformed, unsupported or timed-out sequence

Behaviour:
- Reset: state GROUND; o_cmd, o_char, o_arg0, o_arg1 and the timer are 0; o_cmd_v and o_err are 0. Reset mid-sequence discards the partial sequence silently.
- All outputs are registered. Latency: o_cmd_v or o_err asserts in the cycle after the i_byte_v that completes or breaks a sequence. At most one strobe per input byte. There is no backpressure because bytes arrive at least 40000 clocks apart.
- The payload holds its value until the next strobe.
- States: GROUND, ESC, CSI.
- GROUND:
  - 0x20..0x7E -> CMD_PUTC with o_char = byte.
  - 0x0D -> CR; 0x0A -> LF; 0x08 -> BS; 0x09 -> TAB; 0x07 -> BEL.
  - 0x1B -> ESC.
  - All other bytes are ignored with no strobe.
- ESC:
  - '[' -> CSI; clear p0 and p1, idx = 0, and the "seen" flags.
  - 'c' -> CMD_RIS, then GROUND.
  - 0x1B stays in ESC.
  - Any other byte -> o_err, then GROUND.
- CSI:
  - Digits: p[idx] = p[idx]*10 + digit, saturating at PARAM_MAX. Compute in at least 12 bits, then clamp. Set seen[idx].
  - ';': idx increments. A third or later parameter is parsed but discarded; idx saturates at 2.
  - Final bytes map as follows:
    - 'A','B','C','D' -> CUU, CUD, CUF, CUB; arg0 = p0, with 0 or missing -> 1.
    - 'H' or 'f' -> CUP; arg0 = p0 and arg1 = p1, each with 0 or missing -> 1.
    - 'J' -> ED; 'K' -> EL; arg0 = p0, missing -> 0; values >2 -> o_err.
    - Any other byte in 0x40..0x7E -> o_err.
  - After any final byte, go to GROUND.
  - 0x1B restarts ESC with no error. CAN 0x18 or SUB 0x1A -> GROUND with no strobe.
  - Other bytes below 0x40 (e.g. '?', intermediates) or above 0x7E -> o_err, then GROUND.
- Timer:
  - Cleared on every i_byte_v and held at 0 in GROUND.
  - Otherwise increments each clock. On reaching TIMEOUT_CLKS-1 it pulses o_err and returns to GROUND.
  - If i_byte_v arrives in the same cycle the timer expires, the byte wins: it is processed in the current state and the timer clears.

Decomposition:
- ansi_pkg holds:
  - CMD_* codes: PUTC=0, CR=1, LF=2, BS=3, TAB=4, BEL=5, CUU=6, CUD=7, CUF=8, CUB=9, CUP=10, ED=11, EL=12, RIS=13.
  - State encodings.
  - Character constants: ESC, CSI '[', CAN, SUB.
- One sub-module, ansi_param_acc, is natural: the saturating decimal accumulator, with clear, digit-valid and digit inputs and an 8-bit value plus a seen flag. It is instantiated twice.

Test Plan:
- Bytes 'A', 0x0D, 0x0A -> three strobes: PUTC with o_char=0x41, then CR, then LF. Each strobe is one cycle after its i_byte_v.
- "ESC[12;40H" -> a single CUP with arg0=12 and arg1=40. "ESC[H" -> CUP 1,1. "ESC[;5H" -> CUP 1,5.
- "ESC[C" -> CUF arg0=1. "ESC[999B" -> CUD arg0=255 (saturated). "ESC[2J" -> ED arg0=2. "ESC[5K" -> o_err, no o_cmd_v.
- "ESC[3" followed by silence -> o_err exactly TIMEOUT_CLKS clocks after the '3' strobe. The next 'x' -> PUTC 0x78. Also check with a byte coinciding with the expiry cycle: the byte is processed and no o_err fires.
- "ESC[1" then ESC "[4A" -> CUU arg0=4, no o_err. "ESC[2" then CAN -> no strobe; the following 'z' is decoded as PUTC.
- Assert rst_n low after "ESC[7" and release -> state GROUND with all outputs 0. Then 'B' -> PUTC 0x42. Also check: "ESC c" -> RIS, and byte 0x80 in GROUND -> no strobe.
